alu_regbank: RTL
================

Name: alu_regbank

Overview:
Parametrised operand register bank that feeds the ALU. It has one write port and two read ports. The two read values are packed into one 2*DATA_W operand word, with a selectable pairing mode. It adds behaviour the first-generation bank lacks: real clocked storage, 1-cycle registered reads, optional write-to-read bypass, an out-of-range address flag, and a sequenced clear-all state machine.

Parameters:
DATA_W, 4, width of each register and of each operand half
DEPTH, 4, number of registers (any value >= 2; need not be a power of 2)
BYPASS, 1, 1 = a same-cycle write is forwarded to the reads; 0 = reads return the pre-write contents

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write register index (ADDR_W = max(1, clog2(DEPTH)))
wr_data  in  DATA_W  write data
rd_en  in  1  read strobe
rd_addr_a  in  ADDR_W  operand A register index
rd_addr_b  in  ADDR_W  operand B register index
mode  in  2  operand pairing: 00 {B,B}, 01 {B,A}, 10 {A,B}, 11 {A,A} (upper half listed first)
clr_req  in  1  request to clear all registers
data_out  out  2*DATA_W  packed operand word
rd_valid  out  1  data_out updated this cycle (1-cycle pulse per read)
busy  out  1  clear sequence in progress
addr_err  out  1  1-cycle pulse: an accepted access used an index >= DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0; data_out 0; rd_valid 0; busy 0; addr_err 0.
  - FSM goes to IDLE and the clear counter goes to 0, including when reset arrives mid-clear.
- Write: in IDLE with wr_en=1 and wr_addr < DEPTH, reg[wr_addr] <= wr_data at the edge.
- Read:
  - In IDLE with rd_en=1, operands are sampled at the edge.
  - data_out and rd_valid are registered, giving 1-cycle latency: data_out changes on the edge after rd_en, and rd_valid=1 for that cycle only.
  - data_out holds its value when there is no read.
- Pairing: A = value at rd_addr_a, B = value at rd_addr_b. data_out[2*DATA_W-1:DATA_W] = first letter of mode, data_out[DATA_W-1:0] = second letter.
- Bypass (BYPASS=1): if wr_en and rd_en are high in the same cycle and wr_addr equals a read address, that operand takes wr_data. With BYPASS=0 it takes the old contents. The write happens in both cases.
- Out-of-range:
  - A write to an index >= DEPTH is dropped.
  - A read index >= DEPTH yields 0 for that operand.
  - Either case pulses addr_err on the next cycle; one pulse even if several indices are bad.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1. Any write or read in that same cycle is still performed. busy=1 from the next cycle.
  - CLEAR: reg[cnt] <= 0 each cycle, cnt increments from 0. At cnt = DEPTH-1 the state returns to IDLE and cnt returns to 0.
  - busy=1 for exactly DEPTH cycles.
  - In CLEAR, wr_en, rd_en and clr_req are ignored: no write, rd_valid=0, addr_err=0, and no re-trigger.
- addr_err and rd_valid are 0 in any cycle with no accepted access.

Decomposition:
- Shared package alu_pkg holds:
  - mode encodings as named constants: MODE_BB=2'b00, MODE_BA=2'b01, MODE_AB=2'b10, MODE_AA=2'b11;
  - FSM state constants ST_IDLE, ST_CLEAR;
  - a clog2-style function used to derive ADDR_W.
- One natural sub-module: alu_regbank_rdport, a combinational read-with-bypass for one operand (array, address, write-forward inputs, BYPASS, DEPTH). It is instantiated twice, for A and B.
- Pairing mux, FSM, counter and output registers stay in alu_regbank.

Test Plan:
1. Reset, write reg1=4'h3 and reg2=4'hA, then rd_en with a=1, b=2, mode=10 -> next cycle data_out=8'h3A, rd_valid=1 for one cycle. Same read with mode=01 -> 8'hA3; mode=00 -> 8'hAA; mode=11 -> 8'h33.
2. Bypass: reg0=4'h5, then wr_en (addr 0, data 4'hC) with rd_en (a=b=0, mode=11) in the same cycle -> BYPASS=1 gives 8'hCC, BYPASS=0 gives 8'h55; the next read returns 8'hCC in both builds.
3. Clear: fill all four registers with 4'hF, pulse clr_req -> busy high for exactly 4 cycles. A read and a write issued during busy are ignored (rd_valid stays 0, the write is lost). After busy falls, every register reads 0.
4. DEPTH=3 build: write to addr 3 -> addr_err pulses once and the contents are unchanged. Read with a=3, b=0 (reg0=4'h7), mode=10 -> data_out=8'h07 and addr_err pulses.
5. Assert rst_n low for one cycle during the second CLEAR cycle, asynchronously between edges -> busy, data_out and rd_valid drop immediately; all registers read 0 afterwards; a new clr_req again gives exactly DEPTH busy cycles.
6. Back-to-back reads on 4 consecutive cycles with different addresses -> 4 consecutive rd_valid cycles, each data_out matching the address presented one cycle earlier.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand register bank: pairing modes, FSM states
// and the address-width helper.
package alu_pkg;

  localparam logic [1:0] MODE_BB = 2'b00;
  localparam logic [1:0] MODE_BA = 2'b01;
  localparam logic [1:0] MODE_AB = 2'b10;
  localparam logic [1:0] MODE_AA = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Index width for a bank of 'depth' entries, never narrower than one bit.
  function automatic int addrWidth(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alu_regbank_rdport.sv
// One combinational read port of the operand bank.
// Out-of-range indices read as zero; an in-flight write can be forwarded to the read.
module alu_regbank_rdport #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int ADDR_W = 2
) (
  input  logic [DATA_W*DEPTH-1:0] memFlat_i,
  input  logic [ADDR_W-1:0]       rdAddr_i,
  input  logic                    wrEn_i,
  input  logic [ADDR_W-1:0]       wrAddr_i,
  input  logic [DATA_W-1:0]       wrData_i,
  output logic [DATA_W-1:0]       rdData_o
);

  // Only a matching in-range index selects data, so a bad index falls through to zero.
  always_comb begin
    rdData_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdAddr_i == ADDR_W'(i)) begin
        if ((BYPASS != 0) && wrEn_i && (wrAddr_i == rdAddr_i)) begin
          rdData_o = wrData_i;
        end else begin
          rdData_o = memFlat_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/alu_regbank.sv
// Operand register bank for the ALU: one write port, two registered read ports
// packed into one operand word, plus a sequenced clear-all.
module alu_regbank
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addrWidth(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  input  logic [1:0]          mode,
  input  logic                clr_req,
  output logic [2*DATA_W-1:0] data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W*DEPTH-1:0] mem_q, mem_d;
  logic [0:0]              state_q, state_d;
  logic [ADDR_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     dataOut_q, dataOut_d;
  logic                    rdValid_q, rdValid_d;
  logic                    addrErr_q, addrErr_d;

  logic              idle;
  logic              wrOk, rdAOk, rdBOk;
  logic [DATA_W-1:0] opA, opB;

  assign idle  = (state_q == ST_IDLE);
  assign wrOk  = ({1'b0, wr_addr}   < DEPTH_L);
  assign rdAOk = ({1'b0, rd_addr_a} < DEPTH_L);
  assign rdBOk = ({1'b0, rd_addr_b} < DEPTH_L);

  alu_regbank_rdport #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS),
    .ADDR_W (ADDR_W)
  ) u_rdport_a (
    .memFlat_i (mem_q),
    .rdAddr_i  (rd_addr_a),
    .wrEn_i    (idle & wr_en),
    .wrAddr_i  (wr_addr),
    .wrData_i  (wr_data),
    .rdData_o  (opA)
  );

  alu_regbank_rdport #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS),
    .ADDR_W (ADDR_W)
  ) u_rdport_b (
    .memFlat_i (mem_q),
    .rdAddr_i  (rd_addr_b),
    .wrEn_i    (idle & wr_en),
    .wrAddr_i  (wr_addr),
    .wrData_i  (wr_data),
    .rdData_o  (opB)
  );

  // In CLEAR every host request is ignored; the counter walks the bank once.
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    dataOut_d = dataOut_q;
    rdValid_d = 1'b0;
    addrErr_d = 1'b0;
    if (idle) begin
      if (wr_en && wrOk) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_addr == ADDR_W'(i)) mem_d[i*DATA_W +: DATA_W] = wr_data;
        end
      end
      if (rd_en) begin
        rdValid_d = 1'b1;
        case (mode)
          MODE_BB: dataOut_d = {opB, opB};
          MODE_BA: dataOut_d = {opB, opA};
          MODE_AB: dataOut_d = {opA, opB};
          default: dataOut_d = {opA, opA};
        endcase
      end
      addrErr_d = (wr_en && !wrOk) || (rd_en && (!rdAOk || !rdBOk));
      if (clr_req) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q == ADDR_W'(i)) mem_d[i*DATA_W +: DATA_W] = '0;
      end
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dataOut_q <= '0;
      rdValid_q <= 1'b0;
      addrErr_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dataOut_q <= dataOut_d;
      rdValid_q <= rdValid_d;
      addrErr_q <= addrErr_d;
    end
  end

  assign data_out = dataOut_q;
  assign rd_valid = rdValid_q;
  assign addr_err = addrErr_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule
